// File: rtl/lsc_uart_rx_fifo.sv
// Buffered 8N1 UART receiver feeding a first-word-fall-through register FIFO.
// Flags framing errors and overruns with single-cycle pulses.
module lsc_uart_rx_fifo #(
    parameter logic [15:0] PERIOD     = 16'd867,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rxd,
    output logic [7:0]            o_dout,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_frame_err,
    output logic                  o_overrun
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic        sync1_q, rxd_s_q, rxd_prev_q;
    logic        fall;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        cnt_zero;
    logic        push;
    logic        frame_err_d, frame_err_q;
    logic        overrun_d, overrun_q;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  pop, full, wr_en;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            sync1_q    <= i_rxd;
            rxd_s_q    <= sync1_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    assign fall     = rxd_prev_q & ~rxd_s_q;
    assign cnt_zero = (cnt_q == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (fall) state_d = S_START;
            S_START: if (cnt_zero) state_d = rxd_s_q ? S_IDLE : S_DATA;
            S_DATA:  if (cnt_zero && idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (cnt_zero) state_d = rxd_s_q ? S_IDLE : S_BREAK;
            S_BREAK: if (rxd_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall) cnt_d = PERIOD >> 1;
            end
            S_START: begin
                if (cnt_zero) begin
                    cnt_d = PERIOD;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shreg_d = {rxd_s_q, shreg_q[7:1]};
                    cnt_d   = PERIOD;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    push        = rxd_s_q;
                    frame_err_d = ~rxd_s_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign pop       = (count_q != '0) & i_ready;
    assign full      = (count_q == DEPTH_C);
    assign wr_en     = push & (~full | pop);
    assign overrun_d = push & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_dout      = mem_q[rd_ptr_q];
    assign o_valid     = (count_q != '0);
    assign o_count     = count_q;
    assign o_full      = full;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_lsc_uart_rx_fifo.sv
// Bench for lsc_uart_rx_fifo: queue model timed from the frame start,
// checked every cycle, plus literal expectations for each scenario.
module tb_lsc_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       i_rxd;
    logic [7:0] o_dout;
    logic       o_valid;
    logic       i_ready;
    logic [2:0] o_count;
    logic       o_full;
    logic       o_frame_err;
    logic       o_overrun;

    lsc_uart_rx_fifo #(
        .PERIOD     (16'd15),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rxd       (i_rxd),
        .o_dout      (o_dout),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    logic [7:0] model[$];
    logic [7:0] log_q[$];
    logic       ev_valid = 1'b0;
    logic [7:0] ev_byte  = 8'd0;
    logic       ev_stop  = 1'b0;
    logic       exp_f    = 1'b0;
    logic       exp_o    = 1'b0;
    int         ferr_seen = 0;
    int         ovr_seen  = 0;
    int         rise_n    = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end else begin
            passes++;
        end
    endtask

    // Per-cycle compare; the model advances on the edge that follows.
    always begin
        @(negedge clk);
        #2;
        if (o_frame_err) ferr_seen++;
        if (o_overrun) ovr_seen++;
        if (reset) begin
            model.delete();
            exp_f    = 1'b0;
            exp_o    = 1'b0;
            ev_valid = 1'b0;
            chk("rst_count", 32'(o_count), 0);
            chk("rst_valid", 32'(o_valid), 0);
            chk("rst_ferr", 32'(o_frame_err), 0);
            chk("rst_ovr", 32'(o_overrun), 0);
        end else begin
            chk("count", 32'(o_count), 32'(model.size()));
            chk("valid", 32'(o_valid), 32'(model.size() != 0));
            chk("full", 32'(o_full), 32'(model.size() == DEPTH));
            if (model.size() != 0) chk("dout", 32'(o_dout), 32'(model[0]));
            chk("frame_err", 32'(o_frame_err), 32'(exp_f));
            chk("overrun", 32'(o_overrun), 32'(exp_o));
            exp_f = 1'b0;
            exp_o = 1'b0;
            if (model.size() != 0 && i_ready) log_q.push_back(model.pop_front());
            if (ev_valid) begin
                ev_valid = 1'b0;
                if (!ev_stop) exp_f = 1'b1;
                else if (model.size() < DEPTH) model.push_back(ev_byte);
                else exp_o = 1'b1;
            end
        end
    end

    // One 8N1 frame at 16 clk/bit; stop sample falls on the edge after n=154.
    task automatic frame(input logic [7:0] b, input logic stopb,
                         input int pulse);
        logic [9:0] bits;
        bits   = {stopb, b, 1'b0};
        rise_n = -1;
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            if (o_valid && rise_n < 0) rise_n = n;
            i_rxd = bits[n/16];
            if (pulse >= 0) i_ready = (n == pulse);
            if (n == 154) begin
                ev_byte  = b;
                ev_stop  = stopb;
                ev_valid = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_rxd = lvl;
        end
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        @(negedge clk);
        i_ready = 1'b1;
        while (o_count != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        i_ready = 1'b0;
        chk("drain_timeout", 32'(cyc < 40), 1);
    endtask

    int         cyc;
    logic [7:0] bits_c3;

    initial begin
        reset   = 1'b1;
        i_rxd   = 1'b1;
        i_ready = 1'b0;
        #1;
        chk("init_dout", 32'(o_dout), 0);
        chk("init_full", 32'(o_full), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(1'b1, 5);

        // single byte
        frame(8'hA5, 1'b1, -1);
        chk("t1_rise", 32'(rise_n), 155);
        chk("t1_dout", 32'(o_dout), 32'h A5);
        chk("t1_count", 32'(o_count), 1);
        log_q.delete();
        drain(cyc);
        chk("t1_pop", 32'(log_q[0]), 32'h A5);

        // fill, overrun, drain
        frame(8'h00, 1'b1, -1);
        frame(8'hFF, 1'b1, -1);
        frame(8'h3C, 1'b1, -1);
        frame(8'h81, 1'b1, -1);
        chk("t2_full", 32'(o_full), 1);
        frame(8'h55, 1'b1, -1);
        chk("t2_ovr", 32'(ovr_seen), 1);
        chk("t2_count", 32'(o_count), 4);
        log_q.delete();
        drain(cyc);
        chk("t2_cycles", 32'(cyc), 4);
        chk("t2_n", 32'(log_q.size()), 4);
        chk("t2_b0", 32'(log_q[0]), 32'h00);
        chk("t2_b1", 32'(log_q[1]), 32'h FF);
        chk("t2_b2", 32'(log_q[2]), 32'h3C);
        chk("t2_b3", 32'(log_q[3]), 32'h81);

        // push and pop together while full
        frame(8'h11, 1'b1, -1);
        frame(8'h22, 1'b1, -1);
        frame(8'h33, 1'b1, -1);
        frame(8'h44, 1'b1, -1);
        log_q.delete();
        frame(8'h55, 1'b1, 154);
        chk("t3_ovr", 32'(ovr_seen), 1);
        chk("t3_count", 32'(o_count), 4);
        chk("t3_popped", 32'(log_q[0]), 32'h11);
        log_q.delete();
        drain(cyc);
        chk("t3_n", 32'(log_q.size()), 4);
        chk("t3_tail", 32'(log_q[3]), 32'h55);

        // framing error then recovery
        frame(8'h12, 1'b0, -1);
        idle(1'b0, 40);
        idle(1'b1, 10);
        chk("t4_ferr", 32'(ferr_seen), 1);
        chk("t4_empty", 32'(o_count), 0);
        frame(8'h34, 1'b1, -1);
        chk("t4_dout", 32'(o_dout), 32'h34);
        drain(cyc);

        // false start glitch
        idle(1'b0, 6);
        idle(1'b1, 30);
        chk("t5_count", 32'(o_count), 0);
        chk("t5_ferr", 32'(ferr_seen), 1);
        frame(8'h7E, 1'b1, -1);
        chk("t5_dout", 32'(o_dout), 32'h7E);
        drain(cyc);

        // reset mid-frame
        frame(8'h01, 1'b1, -1);
        frame(8'h02, 1'b1, -1);
        chk("t6_pre", 32'(o_count), 2);
        bits_c3 = 8'hC3;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            i_rxd = (n < 16) ? 1'b0 : bits_c3[(n/16)-1];
        end
        @(negedge clk);
        reset = 1'b1;
        i_rxd = 1'b1;
        #1;
        chk("t6_count", 32'(o_count), 0);
        chk("t6_valid", 32'(o_valid), 0);
        chk("t6_dout", 32'(o_dout), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1, 10);
        frame(8'h99, 1'b1, -1);
        idle(1'b1, 4);
        chk("t6_rx", 32'(o_dout), 32'h99);
        chk("t6_cnt1", 32'(o_count), 1);
        drain(cyc);

        idle(1'b1, 5);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
